// File: rtl/mrd_stage_sched.sv
// Stage scheduler for the mixed-radix DFT core: arbitrates the shared butterfly engine
// between two ping-pong banks, factors the granted frame size and issues one stage at a time.
module mrd_stage_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [11:0] dftpts0,
    input  logic [11:0] dftpts1,
    input  logic        inverse0,
    input  logic        inverse1,
    input  logic        stage_done,
    output logic        sw_1to0,
    output logic        busy,
    output logic        stage_start,
    output logic [2:0]  stage_rdx,
    output logic [2:0]  stage_idx,
    output logic [11:0] stage_span,
    output logic        stage_last,
    output logic        stage_inverse,
    output logic [2:0]  nstages,
    output logic        frame_done0,
    output logic        frame_done1,
    output logic        frame_err,
    output logic [2:0]  dbg_state
);

    // Handshakes: a bank holds reqN high until its one-cycle frame_doneN pulse; each
    // stage_start pulse is answered by exactly one stage_done pulse, which only counts in WAIT.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FACT  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t      state_q;
    logic [11:0] n_tot_q;
    logic [11:0] r_q;
    logic [2:0]  cnt_q;
    logic        last_served_q;

    logic [2:0]  fact_rdx;
    logic [11:0] fact_div;
    logic [2:0]  first_rdx;
    logic [11:0] wait_r;
    logic [2:0]  wait_rdx;
    logic [11:0] wait_span;
    logic [2:0]  idx_inc;
    logic [2:0]  last_idx;
    logic        grant_any;
    logic        grant_bank;

    // First matching radix wins; 0 means the residual has no supported factor.
    function automatic logic [2:0] pick_radix(input logic [11:0] r);
        logic [2:0] rdx;
        if (r[1:0] == 2'b00)
            rdx = 3'd4;
        else if (!r[0])
            rdx = 3'd2;
        else if ((r % 12'd3) == 12'd0)
            rdx = 3'd3;
        else if ((r % 12'd5) == 12'd0)
            rdx = 3'd5;
        else
            rdx = 3'd0;
        return rdx;
    endfunction

    function automatic logic [11:0] div_radix(input logic [11:0] r, input logic [2:0] rdx);
        logic [11:0] q;
        case (rdx)
            3'd2:    q = r >> 1;
            3'd3:    q = r / 12'd3;
            3'd4:    q = r >> 2;
            3'd5:    q = r / 12'd5;
            default: q = r;
        endcase
        return q;
    endfunction

    function automatic logic [11:0] mul_radix(input logic [11:0] s, input logic [2:0] rdx);
        logic [11:0] p;
        case (rdx)
            3'd2:    p = s << 1;
            3'd3:    p = (s << 1) + s;
            3'd4:    p = s << 2;
            3'd5:    p = (s << 2) + s;
            default: p = s;
        endcase
        return p;
    endfunction

    always_comb begin
        fact_rdx   = pick_radix(r_q);
        fact_div   = div_radix(r_q, fact_rdx);
        first_rdx  = pick_radix(n_tot_q);
        wait_r     = div_radix(r_q, stage_rdx);
        wait_rdx   = pick_radix(wait_r);
        wait_span  = mul_radix(stage_span, stage_rdx);
        idx_inc    = stage_idx + 3'd1;
        last_idx   = nstages - 3'd1;
        grant_any  = req0 | req1;
        // On contention the bank not served last wins.
        grant_bank = (req0 && req1) ? ~last_served_q : req1;
    end

    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            n_tot_q       <= 12'd0;
            r_q           <= 12'd0;
            cnt_q         <= 3'd0;
            last_served_q <= 1'b1;
            sw_1to0       <= 1'b0;
            busy          <= 1'b0;
            stage_start   <= 1'b0;
            stage_rdx     <= 3'd0;
            stage_idx     <= 3'd0;
            stage_span    <= 12'd0;
            stage_last    <= 1'b0;
            stage_inverse <= 1'b0;
            nstages       <= 3'd0;
            frame_done0   <= 1'b0;
            frame_done1   <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            stage_start <= 1'b0;
            frame_done0 <= 1'b0;
            frame_done1 <= 1'b0;
            frame_err   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_any) begin
                        sw_1to0       <= grant_bank;
                        n_tot_q       <= grant_bank ? dftpts1 : dftpts0;
                        r_q           <= grant_bank ? dftpts1 : dftpts0;
                        stage_inverse <= grant_bank ? inverse1 : inverse0;
                        busy          <= 1'b1;
                        cnt_q         <= 3'd0;
                        nstages       <= 3'd0;
                        state_q       <= S_FACT;
                    end
                end
                S_FACT: begin
                    if (n_tot_q < 12'd2 || (r_q != 12'd1 && fact_rdx == 3'd0)) begin
                        frame_err   <= 1'b1;
                        frame_done0 <= ~sw_1to0;
                        frame_done1 <= sw_1to0;
                        state_q     <= S_ERR;
                    end else if (r_q == 12'd1) begin
                        // Validation pass complete: rewind the residual and issue stage 0.
                        nstages     <= cnt_q;
                        r_q         <= n_tot_q;
                        stage_rdx   <= first_rdx;
                        stage_idx   <= 3'd0;
                        stage_span  <= 12'd1;
                        stage_last  <= (cnt_q == 3'd1);
                        stage_start <= 1'b1;
                        state_q     <= S_ISSUE;
                    end else begin
                        r_q   <= fact_div;
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (stage_done) begin
                        if (stage_last) begin
                            frame_done0 <= ~sw_1to0;
                            frame_done1 <= sw_1to0;
                            state_q     <= S_DONE;
                        end else begin
                            r_q         <= wait_r;
                            stage_rdx   <= wait_rdx;
                            stage_span  <= wait_span;
                            stage_idx   <= idx_inc;
                            stage_last  <= (idx_inc == last_idx);
                            stage_start <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    last_served_q <= sw_1to0;
                    busy          <= 1'b0;
                    state_q       <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mrd_stage_sched.sv
// Bench for mrd_stage_sched: scenario tasks drive requests, a bank responder answers stages,
// and a scoreboard compares every stage_start and frame end against expected records.
module tb_mrd_stage_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [11:0] dftpts0, dftpts1;
    logic        inverse0, inverse1;
    logic        stage_done;
    logic        sw_1to0, busy, stage_start;
    logic [2:0]  stage_rdx, stage_idx;
    logic [11:0] stage_span;
    logic        stage_last, stage_inverse;
    logic [2:0]  nstages;
    logic        frame_done0, frame_done1, frame_err;
    logic [2:0]  dbg_state;

    logic        drv_done;
    logic        resp_done;
    logic        auto_done;
    int          resp_wait;

    int n_cmp = 0;
    int n_bad = 0;

    // Stage record {bank, inverse, rdx, idx, span, last, nstages}; end record {err, done1, done0}.
    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];
    logic [2:0]  exp_done_q[$];
    logic [2:0]  obs_done_q[$];

    wire [28:0] all_outs = {sw_1to0, busy, stage_start, stage_rdx, stage_idx, stage_span,
                            stage_last, stage_inverse, nstages, frame_done0, frame_done1, frame_err};

    assign stage_done = drv_done | resp_done;

    mrd_stage_sched dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .dftpts0(dftpts0), .dftpts1(dftpts1), .inverse0(inverse0), .inverse1(inverse1),
        .stage_done(stage_done), .sw_1to0(sw_1to0), .busy(busy), .stage_start(stage_start),
        .stage_rdx(stage_rdx), .stage_idx(stage_idx), .stage_span(stage_span),
        .stage_last(stage_last), .stage_inverse(stage_inverse), .nstages(nstages),
        .frame_done0(frame_done0), .frame_done1(frame_done1), .frame_err(frame_err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        dftpts0 = 12'd0; dftpts1 = 12'd0;
        inverse0 = 1'b0; inverse1 = 1'b0;
        drv_done = 1'b0; auto_done = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        exp_q.delete(); obs_q.delete(); exp_done_q.delete(); obs_done_q.delete();
    endtask

    // ---------------- bank responder and monitor ----------------
    always @(negedge clk) begin
        resp_done = 1'b0;
        if (rst)
            resp_wait = 0;
        else if (stage_start && auto_done)
            resp_wait = $urandom_range(1, 3);
        else if (resp_wait != 0) begin
            resp_wait = resp_wait - 1;
            if (resp_wait == 0) resp_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (stage_start)
            obs_q.push_back({sw_1to0, stage_inverse, stage_rdx, stage_idx, stage_span, stage_last, nstages});
        if (frame_done0 || frame_done1 || frame_err)
            obs_done_q.push_back({frame_err, frame_done1, frame_done0});
    end

    // ---------------- expectation builders ----------------
    function automatic void push_stage(input logic bank, input logic inv, input logic [2:0] rdx,
                                       input logic [2:0] idx, input logic [11:0] span,
                                       input logic last, input logic [2:0] nst);
        exp_q.push_back({bank, inv, rdx, idx, span, last, nst});
    endfunction

    function automatic void push_end(input logic err, input logic bank);
        exp_done_q.push_back({err, bank, ~bank});
    endfunction

    // Reference factoring: greedy 4, 2, 3, 5 on the remaining size.
    function automatic void model_frame(input logic bank, input logic [11:0] n, input logic inv);
        int rem;
        int span;
        int rd[$];
        bit bad;
        rem = int'(n);
        bad = (n < 12'd2);
        while (!bad && rem > 1) begin
            if (rem % 4 == 0) rd.push_back(4);
            else if (rem % 2 == 0) rd.push_back(2);
            else if (rem % 3 == 0) rd.push_back(3);
            else if (rem % 5 == 0) rd.push_back(5);
            else bad = 1'b1;
            if (!bad) rem = rem / rd[rd.size() - 1];
        end
        if (!bad) begin
            span = 1;
            for (int i = 0; i < rd.size(); i++) begin
                push_stage(bank, inv, 3'(rd[i]), 3'(i), 12'(span), (i == rd.size() - 1), 3'(rd.size()));
                span = span * rd[i];
            end
        end
        push_end(bad, bank);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_fd(input logic bank, input string tag);
        int c;
        c = 0;
        do begin
            tick();
            c++;
        end while (!(bank ? frame_done1 : frame_done0) && c < 400);
        n_cmp++;
        if (!(bank ? frame_done1 : frame_done0)) begin
            n_bad++;
            $display("FAIL %s timeout: frame_done%0d not seen after %0d cycles, required within 400", tag, bank, c);
        end
        if (bank) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic [23:0] e, o;
        logic [2:0]  ed, od;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL %s stage: no stage_start seen, required %h", tag, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL %s stage: got %h required %h", tag, o, e);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s stage: %0d extra stage_start, required 0", tag, obs_q.size());
            obs_q.delete();
        end
        while (exp_done_q.size() > 0) begin
            ed = exp_done_q.pop_front();
            n_cmp++;
            if (obs_done_q.size() == 0) begin
                n_bad++;
                $display("FAIL %s end: no frame end seen, required %b", tag, ed);
            end else begin
                od = obs_done_q.pop_front();
                if (od !== ed) begin
                    n_bad++;
                    $display("FAIL %s end: got err/d1/d0=%b required %b", tag, od, ed);
                end
            end
        end
        n_cmp++;
        if (obs_done_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s end: %0d extra frame ends, required 0", tag, obs_done_q.size());
            obs_done_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_dut();
        n_cmp++;
        if (all_outs !== 29'd0) begin
            n_bad++;
            $display("FAIL reset outputs: got %h required 0", all_outs);
        end
        n_cmp++;
        if (dbg_state !== 3'd0) begin
            n_bad++;
            $display("FAIL reset state: got %0d required 0", dbg_state);
        end
    endtask

    task automatic test_size12();
        int c;
        reset_dut();
        push_stage(1'b0, 1'b0, 3'd4, 3'd0, 12'd1, 1'b0, 3'd2);
        push_stage(1'b0, 1'b0, 3'd3, 3'd1, 12'd4, 1'b1, 3'd2);
        push_end(1'b0, 1'b0);
        dftpts0 = 12'd12; req0 = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b1 || sw_1to0 !== 1'b0) begin
            n_bad++;
            $display("FAIL size12 grant: busy=%b sw=%b required busy=1 sw=0", busy, sw_1to0);
        end
        c = 1;
        while (!stage_start && c < 50) begin tick(); c++; end
        n_cmp++;
        if (c !== 4) begin
            n_bad++;
            $display("FAIL size12 first start: cycle %0d required 4", c);
        end
        tick();
        drv_done = 1'b1; tick(); drv_done = 1'b0;
        n_cmp++;
        if (stage_start !== 1'b1) begin
            n_bad++;
            $display("FAIL size12 handoff: stage_start=%b one cycle after stage_done, required 1", stage_start);
        end
        tick();
        drv_done = 1'b1; tick(); drv_done = 1'b0;
        n_cmp++;
        if (frame_done0 !== 1'b1 || nstages !== 3'd2) begin
            n_bad++;
            $display("FAIL size12 end: frame_done0=%b nstages=%0d required 1 and 2", frame_done0, nstages);
        end
        req0 = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL size12 busy clear: busy=%b required 0", busy);
        end
        drain("size12");
    endtask

    task automatic test_size1200_inv();
        reset_dut();
        push_stage(1'b1, 1'b1, 3'd4, 3'd0, 12'd1,   1'b0, 3'd5);
        push_stage(1'b1, 1'b1, 3'd4, 3'd1, 12'd4,   1'b0, 3'd5);
        push_stage(1'b1, 1'b1, 3'd3, 3'd2, 12'd16,  1'b0, 3'd5);
        push_stage(1'b1, 1'b1, 3'd5, 3'd3, 12'd48,  1'b0, 3'd5);
        push_stage(1'b1, 1'b1, 3'd5, 3'd4, 12'd240, 1'b1, 3'd5);
        push_end(1'b0, 1'b1);
        auto_done = 1'b1;
        dftpts1 = 12'd1200; inverse1 = 1'b1; req1 = 1'b1;
        tick(); tick();
        dftpts1 = 12'd7; inverse1 = 1'b0;
        wait_fd(1'b1, "size1200");
        n_cmp++;
        if (sw_1to0 !== 1'b1 || stage_inverse !== 1'b1 || nstages !== 3'd5) begin
            n_bad++;
            $display("FAIL size1200 frame: sw=%b inv=%b nstages=%0d required 1 1 5", sw_1to0, stage_inverse, nstages);
        end
        tick(); tick();
        drain("size1200");
    endtask

    task automatic test_size2048();
        reset_dut();
        push_stage(1'b0, 1'b0, 3'd4, 3'd0, 12'd1,    1'b0, 3'd6);
        push_stage(1'b0, 1'b0, 3'd4, 3'd1, 12'd4,    1'b0, 3'd6);
        push_stage(1'b0, 1'b0, 3'd4, 3'd2, 12'd16,   1'b0, 3'd6);
        push_stage(1'b0, 1'b0, 3'd4, 3'd3, 12'd64,   1'b0, 3'd6);
        push_stage(1'b0, 1'b0, 3'd4, 3'd4, 12'd256,  1'b0, 3'd6);
        push_stage(1'b0, 1'b0, 3'd2, 3'd5, 12'd1024, 1'b1, 3'd6);
        push_end(1'b0, 1'b0);
        auto_done = 1'b1;
        dftpts0 = 12'd2048; req0 = 1'b1;
        wait_fd(1'b0, "size2048");
        tick(); tick();
        drain("size2048");
    endtask

    task automatic test_back_to_back();
        reset_dut();
        model_frame(1'b0, 12'd12, 1'b0);
        model_frame(1'b1, 12'd60, 1'b0);
        model_frame(1'b0, 12'd10, 1'b0);
        auto_done = 1'b1;
        dftpts0 = 12'd12; dftpts1 = 12'd60; req0 = 1'b1; req1 = 1'b1;
        tick();
        n_cmp++;
        if (sw_1to0 !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL contention first: sw=%b busy=%b required sw=0 busy=1", sw_1to0, busy);
        end
        wait_fd(1'b0, "contention0");
        tick(); tick();
        n_cmp++;
        if (sw_1to0 !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL contention second: sw=%b busy=%b required sw=1 busy=1", sw_1to0, busy);
        end
        dftpts0 = 12'd10; req0 = 1'b1;
        wait_fd(1'b1, "contention1");
        wait_fd(1'b0, "contention2");
        tick(); tick();
        drain("contention");
    endtask

    task automatic test_reject();
        logic [11:0] sizes[3];
        int          lat[3];
        int          c;
        sizes[0] = 12'd14; sizes[1] = 12'd1; sizes[2] = 12'd0;
        lat[0] = 3; lat[1] = 2; lat[2] = 2;
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            push_end(1'b1, 1'b0);
            dftpts0 = sizes[k]; req0 = 1'b1;
            c = 0;
            do begin tick(); c++; end while (!frame_done0 && c < 50);
            n_cmp++;
            if (c !== lat[k] || frame_err !== 1'b1) begin
                n_bad++;
                $display("FAIL reject %0d: frame_done0 at cycle %0d err=%b required cycle %0d err=1",
                         sizes[k], c, frame_err, lat[k]);
            end
            req0 = 1'b0;
            tick(); tick();
        end
        drain("reject");
    endtask

    task automatic test_reset_stray();
        int c;
        reset_dut();
        dftpts0 = 12'd12; req0 = 1'b1;
        c = 0;
        while (!stage_start && c < 50) begin tick(); c++; end
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (all_outs !== 29'd0 || dbg_state !== 3'd0) begin
            n_bad++;
            $display("FAIL midframe reset: outs=%h state=%0d required 0 0", all_outs, dbg_state);
        end
        tick();
        rst = 1'b0; req0 = 1'b0;
        exp_q.delete(); obs_q.delete(); exp_done_q.delete(); obs_done_q.delete();
        tick();
        drv_done = 1'b1; tick(); drv_done = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b0 || dbg_state !== 3'd0 || obs_q.size() != 0 || obs_done_q.size() != 0) begin
            n_bad++;
            $display("FAIL stray done: busy=%b state=%0d starts=%0d ends=%0d required 0 0 0 0",
                     busy, dbg_state, obs_q.size(), obs_done_q.size());
        end
        model_frame(1'b0, 12'd12, 1'b0);
        auto_done = 1'b1;
        dftpts0 = 12'd12; req0 = 1'b1;
        tick();
        drv_done = 1'b1; tick(); drv_done = 1'b0;
        c = 2;
        while (!stage_start && c < 50) begin tick(); c++; end
        n_cmp++;
        if (c !== 4) begin
            n_bad++;
            $display("FAIL fact stray: first stage_start at cycle %0d required 4", c);
        end
        wait_fd(1'b0, "fact_stray");
        tick(); tick();
        drain("fact_stray");
    endtask

    task automatic test_random();
        logic        bank, inv;
        logic [11:0] n;
        int          m, r;
        reset_dut();
        auto_done = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bank = 1'($urandom_range(0, 1));
            inv  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                n = 12'($urandom_range(0, 4095));
            end else begin
                m = 1;
                for (int j = 0; j < 8; j++) begin
                    r = $urandom_range(2, 5);
                    if (m * r < 4096) m = m * r;
                end
                n = 12'(m);
            end
            model_frame(bank, n, inv);
            if (bank) begin dftpts1 = n; inverse1 = inv; req1 = 1'b1; end
            else begin dftpts0 = n; inverse0 = inv; req0 = 1'b1; end
            wait_fd(bank, "random");
            tick(); tick();
        end
        drain("random");
    endtask

    initial begin
        test_reset();
        test_size12();
        test_size1200_inv();
        test_size2048();
        test_back_to_back();
        test_reject();
        test_reset_stray();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mrd_stage_sched.md
# mrd_stage_sched

Stage scheduler for the mixed-radix DFT core. The datapath has two ping-pong memory banks (mem0, mem1) and one shared radix-2/3/4/5 butterfly-and-twiddle engine. This block arbitrates which bank owns the engine and drives the engine's `sw_1to0` select. For the granted frame it factors the DFT size into radix stages and issues the stages one at a time, handshaking each with the bank's stage-done report.

## Interface
Parameters: none; widths fixed by the datapath.

- `clk` in 1 — sole clock
- `rst` in 1 — reset, asynchronous, active-high
- `req0`, `req1` in 1 each — bank has a complete frame loaded and requests computation; level, held until its `frame_done`
- `dftpts0`, `dftpts1` in 12 each — frame size of each bank; valid while its req is high
- `inverse0`, `inverse1` in 1 each — IDFT flag of each bank; valid while its req is high
- `stage_done` in 1 — one-cycle pulse from the granted bank: current stage fully written back
- `sw_1to0` out 1 — engine owner: 0 = mem0, 1 = mem1
- `busy` out 1 — a frame is granted
- `stage_start` out 1 — one-cycle pulse: begin stage described by the `stage_*` outputs
- `stage_rdx` out 3 — radix of the current stage (2, 3, 4 or 5)
- `stage_idx` out 3 — stage number, 0-based
- `stage_span` out 12 — product of radices of all earlier stages (1 for stage 0); twiddle stride base
- `stage_last` out 1 — current stage is the final one
- `stage_inverse` out 1 — latched inverse flag of the granted frame
- `nstages` out 3 — stage count of the granted frame
- `frame_done0`, `frame_done1` out 1 each — one-cycle pulse: that bank's frame has finished or been rejected
- `frame_err` out 1 — one-cycle pulse, coincident with `frame_done*`: frame rejected

## Operation
- **States:** IDLE, FACT, ISSUE, WAIT, DONE, ERR.
- **IDLE, arbitration:**
  - If exactly one req is high, grant that bank.
  - If both are high, grant the bank not served last. `last_served` resets to 1, so bank0 wins first.
  - On grant: latch bank into `sw_1to0`, latch `dftpts` into `n_tot` and residual `r`, latch `stage_inverse`, set `busy`=1, clear the stage counter, go to FACT.
- **Factor rule on residual r,** first match wins:
  - r%4==0 → radix 4
  - else r%2==0 → radix 2
  - else r%3==0 → radix 3
  - else r%5==0 → radix 5
  - else no factor.
  - `%3` and `%5` are combinational on 12 bits.
- **FACT (validation pass),** one rule evaluation per cycle:
  - If `n_tot`<2 → ERR.
  - Else if r==1 → load `nstages`=count, reload r=`n_tot`, `stage_idx`=0, `stage_span`=1, go to ISSUE.
  - Else if a factor is found → r=r/radix, count++.
  - Else → ERR.
  - The maximum count for 12-bit sizes is 7; a count of 8 is impossible.
- **ISSUE:**
  - Pulse `stage_start`.
  - `stage_rdx` = rule(r).
  - `stage_last` = (`stage_idx`==`nstages`-1).
  - Go to WAIT.
- **WAIT:**
  - Hold all `stage_*` outputs until `stage_done`.
  - On `stage_done`, if `stage_last` → DONE.
  - Otherwise → ISSUE, with r=r/`stage_rdx`, `stage_span`=`stage_span`×`stage_rdx` (shift/add), and `stage_idx`++.
- **DONE:** pulse `frame_done` of the granted bank, update `last_served`, clear `busy`, go to IDLE.
- **ERR:** pulse `frame_err` and the granted bank's `frame_done`, update `last_served`, clear `busy`, go to IDLE. No `stage_start` is ever issued for a rejected frame.
- `stage_done` outside WAIT is ignored.
- req changes during a granted frame are ignored; all frame data is latched at grant.
- `sw_1to0` holds its value after a frame ends until the next grant.

## Timing
- **Reset values:** all outputs 0 (`sw_1to0`, `busy`, `stage_*`, `nstages`, `frame_done*`, `frame_err`); state IDLE; `last_served`=1.
  - Reset asserted mid-frame aborts the frame immediately.
  - The scheduler does not re-issue the aborted frame; banks are reset together with it.
- **Grant:**
  - req high in IDLE at cycle 0 → `busy`, `sw_1to0` valid from cycle 1.
  - FACT occupies cycles 1..`nstages`+1.
  - First `stage_start` occurs at cycle `nstages`+2.
- **Stage handoff:** `stage_done` in cycle t → next `stage_start` in cycle t+1, with new `stage_*` values in the same cycle.
- **Frame end:**
  - Final `stage_done` at t → `frame_done` at t+1, `busy`=0 at t+2.
  - A new grant can be latched at t+2.
- **Error timing:** an error is detected in the FACT cycle that finds no factor; ERR follows in the next cycle.

## Test plan
1. **Size 12:** `req0`=1, `dftpts0`=12.
   - Expect `stage_start` at cycle 4 with rdx=4, idx=0, span=1.
   - After `stage_done`, expect rdx=3, idx=1, span=4, `stage_last`=1.
   - After `stage_done`, expect `frame_done0` and `nstages`=2.
2. **Size 1200, `inverse1`=1 on bank1:**
   - Expect rdx sequence 4,4,3,5,5 with spans 1,4,16,48,240.
   - Expect `nstages`=5, `stage_inverse`=1, `sw_1to0`=1.
3. **Size 2048:** expect rdx 4,4,4,4,4,2, `stage_last` only on idx 5.
4. **Simultaneous requests:** `req0` and `req1` rise in the same cycle after reset.
   - Expect bank0 served first (`sw_1to0`=0), then bank1 (`sw_1to0`=1).
   - A repeated `req0` during bank1's frame is served after bank1 finishes.
5. **Rejected sizes:** `dftpts0`=14 → `frame_err`+`frame_done0` with no `stage_start`. Repeat with `dftpts0`=1 and with 0.
6. **Reset and stray done:**
   - `rst` pulsed mid-WAIT → all outputs 0 immediately; a later stray `stage_done` is ignored.
   - A `stage_done` injected during FACT is ignored.
